// File: rtl/present80_wb_if.sv
// Wishbone-B4 classic bus bundle between the management core and the PRESENT-80 engine.
interface present80_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/present80_wb_engine.sv
// Wishbone slave wrapping an iterative PRESENT-80 encryptor: one cipher round per clock,
// 32 clocks from the START acknowledge to DONE.
module present80_wb_engine #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFC0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  present80_wb_if.slave    wbs,
  output logic             busy_o,
  output logic             irq_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 64;
  localparam int unsigned KW = 80;
  localparam int unsigned RW = 5;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h1;
  localparam logic [3:0] A_PT_LO  = 4'h2;
  localparam logic [3:0] A_PT_HI  = 4'h3;
  localparam logic [3:0] A_KEY0   = 4'h4;
  localparam logic [3:0] A_KEY1   = 4'h5;
  localparam logic [3:0] A_KEY2   = 4'h6;
  localparam logic [3:0] A_CT_LO  = 4'h7;
  localparam logic [3:0] A_CT_HI  = 4'h8;

  localparam logic [RW-1:0] RC_LAST = RW'(31);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } fsm_t;

  // PRESENT 4-bit substitution box
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Byte-lane write merge
  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [3:0]    be);
    logic [DW-1:0] r;
    r[7:0]   = be[0] ? new_v[7:0]   : old_v[7:0];
    r[15:8]  = be[1] ? new_v[15:8]  : old_v[15:8];
    r[23:16] = be[2] ? new_v[23:16] : old_v[23:16];
    r[31:24] = be[3] ? new_v[31:24] : old_v[31:24];
    return r;
  endfunction

  fsm_t            fsm_q;
  logic            ack_q;
  logic [DW-1:0]   dat_q;
  logic [BW-1:0]   pt_q;
  logic [BW-1:0]   ct_q;
  logic [BW-1:0]   state_q;
  logic [KW-1:0]   key_q;
  logic [KW-1:0]   rk_q;
  logic [RW-1:0]   rc_q;
  logic            irq_en_q;
  logic            done_q;
  logic            busy_q;
  logic            irq_q;

  logic            sel_c;
  logic            acc_c;
  logic            wr_c;
  logic            rd_c;
  logic [3:0]      word_c;
  logic            start_c;
  logic            w1c_c;
  logic            ctrl_wr_c;
  logic            fin_c;
  logic            done_d;
  logic            irq_en_d;
  logic [DW-1:0]   rd_data_c;
  logic [DW-1:0]   wmerge_c;

  logic [BW-1:0]   rnd_in_c;
  logic [BW-1:0]   sb_out_c;
  logic [BW-1:0]   perm_out_c;
  logic [KW-1:0]   key_rot_c;
  logic [KW-1:0]   key_nxt_c;

  // Address decode and access qualification; one access per acknowledge
  assign sel_c     = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                     ((wbs.wbs_adr_i & ADDR_MASK) == ADDR_BASE);
  assign acc_c     = sel_c & ~ack_q;
  assign wr_c      = acc_c & wbs.wbs_we_i;
  assign rd_c      = acc_c & ~wbs.wbs_we_i;
  assign word_c    = wbs.wbs_adr_i[5:2];
  assign ctrl_wr_c = wr_c & (word_c == A_CTRL) & wbs.wbs_sel_i[0];
  assign start_c   = ctrl_wr_c & wbs.wbs_dat_i[0] & ~busy_q;
  assign w1c_c     = wr_c & (word_c == A_STATUS) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1];
  assign fin_c     = (fsm_q == FINAL);

  // DONE: completion beats a same-edge clear; a new START clears it
  assign done_d    = fin_c ? 1'b1 : ((start_c | w1c_c) ? 1'b0 : done_q);
  assign irq_en_d  = ctrl_wr_c ? wbs.wbs_dat_i[1] : irq_en_q;

  // Register read mux; unmapped words read zero
  always_comb begin
    rd_data_c = '0;
    case (word_c)
      A_CTRL:   rd_data_c = {30'd0, irq_en_q, 1'b0};
      A_STATUS: rd_data_c = {30'd0, done_q, busy_q};
      A_PT_LO:  rd_data_c = pt_q[31:0];
      A_PT_HI:  rd_data_c = pt_q[63:32];
      A_KEY0:   rd_data_c = key_q[31:0];
      A_KEY1:   rd_data_c = key_q[63:32];
      A_KEY2:   rd_data_c = {16'd0, key_q[79:64]};
      A_CT_LO:  rd_data_c = ct_q[31:0];
      A_CT_HI:  rd_data_c = ct_q[63:32];
      default:  rd_data_c = '0;
    endcase
  end

  assign wmerge_c = lane_merge(rd_data_c, wbs.wbs_dat_i, wbs.wbs_sel_i);

  // Round datapath: add round key, substitution layer, bit permutation
  assign rnd_in_c = state_q ^ rk_q[79:16];

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign sb_out_c[4*g +: 4] = sbox(rnd_in_c[4*g +: 4]);
  end

  for (genvar g = 0; g < 63; g++) begin : g_perm
    assign perm_out_c[(16*g) % 63] = sb_out_c[g];
  end
  assign perm_out_c[63] = sb_out_c[63];

  // Key schedule: rotate left by 61, substitute top nibble, fold in round counter
  assign key_rot_c = {rk_q[18:0], rk_q[79:19]};
  assign key_nxt_c = {sbox(key_rot_c[79:76]), key_rot_c[75:20],
                      key_rot_c[19:15] ^ rc_q, key_rot_c[14:0]};

  // Bus side: acknowledge, read data, control/status and operand registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      pt_q     <= '0;
      key_q    <= '0;
    end else begin
      ack_q    <= acc_c;
      dat_q    <= rd_c ? rd_data_c : '0;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= done_d & irq_en_d;
      if (wr_c && !busy_q) begin
        case (word_c)
          A_PT_LO: pt_q[31:0]   <= wmerge_c;
          A_PT_HI: pt_q[63:32]  <= wmerge_c;
          A_KEY0:  key_q[31:0]  <= wmerge_c;
          A_KEY1:  key_q[63:32] <= wmerge_c;
          A_KEY2:  key_q[79:64] <= wmerge_c[15:0];
          default: ;
        endcase
      end
    end
  end

  // Cipher sequencer: load on START, 31 rounds, final whitening into CT
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rc_q    <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_c) begin
            state_q <= pt_q;
            rk_q    <= key_q;
            rc_q    <= RW'(1);
            busy_q  <= 1'b1;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          state_q <= perm_out_c;
          rk_q    <= key_nxt_c;
          if (rc_q == RC_LAST) begin
            fsm_q <= FINAL;
          end else begin
            rc_q <= rc_q + RW'(1);
          end
        end
        FINAL: begin
          ct_q   <= state_q ^ rk_q[79:16];
          busy_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign busy_o        = busy_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_present80_wb_engine.sv
// Bench for present80_wb_engine: cycle-level register/bus model with a high-level PRESENT-80
// reference, compared against the DUT on every falling clock edge, plus directed vectors.
module tb_present80_wb_engine;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] MASK     = 32'hFFFF_FFC0;
  // nibble i holds S(i)
  localparam logic [63:0] SBOX_TAB = 64'h21748FE3DA09B65C;
  localparam logic [63:0] CT_V1    = 64'h5579C1387B228445;
  localparam logic [63:0] ONES64   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] ONES80   = {16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy_o;
  logic irq_o;

  int total = 0;
  int bad   = 0;

  present80_wb_if bus();

  present80_wb_engine #(.ADDR_BASE(BASE), .ADDR_MASK(MASK)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wbs       (bus),
    .busy_o    (busy_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // ---------------- reference cipher ----------------
  function automatic logic [3:0] s4(input logic [3:0] x);
    logic [63:0] tab;
    tab = SBOX_TAB;
    return tab[int'(x)*4 +: 4];
  endfunction

  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s, t, p;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      t = s ^ k[79:16];
      for (int n = 0; n < 16; n++) t[n*4 +: 4] = s4(t[n*4 +: 4]);
      p = '0;
      for (int j = 0; j < 64; j++) p[j/4 + 16*(j%4)] = t[j];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = s4(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // ---------------- register/bus model ----------------
  logic        m_ack, m_busy, m_done, m_irq_en, m_acc, m_start;
  logic [31:0] m_dat, m_old, m_new;
  logic [63:0] m_pt, m_ct, run_pt;
  logic [79:0] m_key, run_key;
  logic [3:0]  m_w;
  int          m_edges;

  function automatic logic [31:0] rd_word(input logic [3:0] w);
    case (w)
      4'h0: return {30'd0, m_irq_en, 1'b0};
      4'h1: return {30'd0, m_done, m_busy};
      4'h2: return m_pt[31:0];
      4'h3: return m_pt[63:32];
      4'h4: return m_key[31:0];
      4'h5: return m_key[63:32];
      4'h6: return {16'd0, m_key[79:64]};
      4'h7: return m_ct[31:0];
      4'h8: return m_ct[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack = 0; m_busy = 0; m_done = 0; m_irq_en = 0; m_dat = 0;
      m_pt = 0; m_ct = 0; m_key = 0; run_pt = 0; run_key = 0; m_edges = 0;
    end else begin
      m_acc   = bus.wbs_cyc_i && bus.wbs_stb_i && ((bus.wbs_adr_i & MASK) == BASE) && !m_ack;
      m_w     = bus.wbs_adr_i[5:2];
      m_start = 0;
      m_dat   = (m_acc && !bus.wbs_we_i) ? rd_word(m_w) : 32'd0;
      if (m_acc && bus.wbs_we_i) begin
        m_old = rd_word(m_w);
        m_new = lane_merge(m_old, bus.wbs_dat_i, bus.wbs_sel_i);
        case (m_w)
          4'h0: if (bus.wbs_sel_i[0]) begin
                  m_irq_en = bus.wbs_dat_i[1];
                  m_start  = bus.wbs_dat_i[0] && !m_busy;
                end
          4'h1: if (bus.wbs_sel_i[0] && bus.wbs_dat_i[1]) m_done = 0;
          4'h2: if (!m_busy) m_pt[31:0]   = m_new;
          4'h3: if (!m_busy) m_pt[63:32]  = m_new;
          4'h4: if (!m_busy) m_key[31:0]  = m_new;
          4'h5: if (!m_busy) m_key[63:32] = m_new;
          4'h6: if (!m_busy) m_key[79:64] = m_new[15:0];
          default: ;
        endcase
      end
      m_ack = m_acc;
      if (m_busy) begin
        m_edges++;
        if (m_edges == 32) begin
          m_ct   = present_enc(run_pt, run_key);
          m_done = 1;
          m_busy = 0;
        end
      end
      if (m_start) begin
        run_pt = m_pt; run_key = m_key;
        m_done = 0; m_busy = 1; m_edges = 0;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    chk("ack",   64'(bus.wbs_ack_o), 64'(m_ack));
    chk("dat_o", 64'(bus.wbs_dat_o), 64'(m_dat));
    chk("busy",  64'(busy_o),        64'(m_busy));
    chk("irq",   64'(irq_o),         64'(m_done & m_irq_en));
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata);
    bit got;
    got = 0;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin got = 1; break; end
    end
    rdata = bus.wbs_dat_o;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    if (!got) begin
      total++; bad++;
      $display("FAIL wb_ack_timeout: adr %h ack 0 want 1", adr);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    wb_xfer(1'b1, BASE + 32'(off), dat, sel, d);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    wb_xfer(1'b0, BASE + 32'(off), 32'd0, 4'hF, d);
  endtask

  task automatic load(input logic [63:0] pt, input logic [79:0] key);
    wr(8'h08, pt[31:0], 4'hF);
    wr(8'h0C, pt[63:32], 4'hF);
    wr(8'h10, key[31:0], 4'hF);
    wr(8'h14, key[63:32], 4'hF);
    wr(8'h18, {16'd0, key[79:64]}, 4'hF);
  endtask

  task automatic start_run(input logic irq_bit);
    wr(8'h00, {30'd0, irq_bit, 1'b1}, 4'hF);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      n++;
      if (!busy_o) break;
    end
    if (busy_o) begin
      total++; bad++;
      $display("FAIL done_timeout: busy_o 1 after %0d clocks want 0", n);
    end
  endtask

  task automatic read_ct(output logic [63:0] ct);
    logic [31:0] lo, hi;
    rd(8'h1C, lo);
    rd(8'h20, hi);
    ct = {hi, lo};
  endtask

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  logic [63:0] vec_pt  [3];
  logic [79:0] vec_key [3];
  logic [63:0] vec_ct  [3];

  initial begin
    logic [31:0] d;
    logic [63:0] ct, rpt;
    logic [79:0] rkey;
    int          n;
    logic [3:0]  w;

    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    vec_pt[0] = 64'd0;  vec_key[0] = ONES80; vec_ct[0] = 64'hE72C46C0F5945049;
    vec_pt[1] = ONES64; vec_key[1] = 80'd0;  vec_ct[1] = 64'hA112FFC72F68417B;
    vec_pt[2] = ONES64; vec_key[2] = ONES80; vec_ct[2] = 64'h3333DCD3213210D2;

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_irq",  64'(irq_o),  64'd0);
    for (int a = 0; a < 9; a++) begin
      rd(8'(a * 4), d);
      chk($sformatf("rst_reg%0d", a), 64'(d), 64'd0);
    end

    // Pin the reference cipher to the published vectors
    chk("model_v1", present_enc(64'd0, 80'd0), CT_V1);
    for (int v = 0; v < 3; v++)
      chk($sformatf("model_v%0d", v + 2), present_enc(vec_pt[v], vec_key[v]), vec_ct[v]);

    // Vector 1 with latency
    load(64'd0, 80'd0);
    start_run(1'b0);
    wait_done(n);
    chk("v1_latency", 64'(n), 64'd32);
    rd(8'h04, d);
    chk("v1_status", 64'(d), 64'h2);
    read_ct(ct);
    chk("v1_ct", ct, CT_V1);

    // Vectors 2..4
    for (int v = 0; v < 3; v++) begin
      load(vec_pt[v], vec_key[v]);
      start_run(1'b0);
      wait_done(n);
      read_ct(ct);
      chk($sformatf("v%0d_ct", v + 2), ct, vec_ct[v]);
    end

    // Busy protection
    load(64'd0, 80'd0);
    start_run(1'b0);
    repeat (5) @(posedge clk);
    #1;
    wr(8'h08, 32'h0000_DEAD, 4'hF);
    start_run(1'b0);
    wait_done(n);
    read_ct(ct);
    chk("busy_ct", ct, CT_V1);
    rd(8'h08, d);
    chk("busy_pt_kept", 64'(d), 64'd0);
    wr(8'h04, 32'h2, 4'hF);
    repeat (40) @(posedge clk);
    #1;
    rd(8'h04, d);
    chk("busy_single_done", 64'(d), 64'd0);

    // IRQ and W1C
    wr(8'h00, 32'h2, 4'hF);
    start_run(1'b1);
    wait_done(n);
    chk("irq_rise", 64'(irq_o), 64'd1);
    wr(8'h04, 32'h2, 4'hF);
    chk("irq_clear", 64'(irq_o), 64'd0);
    rd(8'h04, d);
    chk("w1c_status", 64'(d), 64'd0);

    // W1C landing on the completion edge
    start_run(1'b1);
    repeat (31) @(posedge clk);
    #1;
    wr(8'h04, 32'h2, 4'hF);
    chk("e32_busy", 64'(busy_o), 64'd0);
    rd(8'h04, d);
    chk("e32_done_wins", 64'(d), 64'h2);
    chk("e32_irq", 64'(irq_o), 64'd1);

    // Reset mid-operation
    wr(8'h00, 32'h0, 4'hF);
    load(ONES64, ONES80);
    start_run(1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_irq",  64'(irq_o),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    read_ct(ct);
    chk("midrst_ct", ct, 64'd0);
    load(64'd0, 80'd0);
    start_run(1'b0);
    wait_done(n);
    read_ct(ct);
    chk("midrst_rerun_ct", ct, CT_V1);

    // Byte lanes, unmapped words, out-of-window
    wr(8'h10, 32'hFFFF_FFFF, 4'hF);
    wr(8'h10, 32'h1234_5678, 4'b0001);
    rd(8'h10, d);
    chk("sel_key0", 64'(d), 64'hFFFF_FF78);
    wr(8'h3C, 32'hFFFF_FFFF, 4'hF);
    rd(8'h3C, d);
    chk("unmapped_3c", 64'(d), 64'd0);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
    bus.wbs_adr_i = BASE + 32'h40; bus.wbs_sel_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("oow_noack", 64'(bus.wbs_ack_o), 64'd0);
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    @(posedge clk); #1;

    // Randomized register traffic and encryptions
    for (int it = 0; it < 80; it++) begin
      if (it % 10 == 9) begin
        wait_done(n);
        wr(8'h04, 32'h2, 4'h1);
        rpt  = {$urandom(), $urandom()};
        rkey = {16'($urandom()), $urandom(), $urandom()};
        load(rpt, rkey);
        start_run(1'($urandom_range(1)));
        wait_done(n);
        chk("rand_latency", 64'(n), 64'd32);
        read_ct(ct);
        chk("rand_ct", ct, present_enc(rpt, rkey));
      end else begin
        w = 4'($urandom_range(15));
        wb_xfer(1'($urandom_range(1)), BASE + {26'd0, w, 2'b00}, $urandom(),
                4'($urandom_range(15)), d);
      end
    end
    wait_done(n);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
